// File: rtl/memory_responder_if.sv
// Memory request/response handshake between the control unit and the RAM.
// Latency: none (wires only).
// Backpressure: level handshake; the initiator holds memEn until mfc, then drops it.
//
// Signals:
//   memEn    request strobe, held high by the initiator until mfc
//   memRW    0 = read, 1 = write
//   address  byte address (only the low bits the responder decodes are used)
//   dataIn   write data, right-justified
//   dataType 00 byte, 01 halfword, 10/11 word
//   dataOut  read data, right-justified, zero-extended
//   mfc      memory function complete
interface memory_responder_if;
  logic        memEn;
  logic        memRW;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [1:0]  dataType;
  logic [31:0] dataOut;
  logic        mfc;

  // Control unit side.
  modport master (
    output memEn, memRW, address, dataIn, dataType,
    input  dataOut, mfc
  );

  // RAM side.
  modport slave (
    input  memEn, memRW, address, dataIn, dataType,
    output dataOut, mfc
  );
endinterface

// File: rtl/memory_responder.sv
// Byte-addressable big-endian RAM answering the processor's memEn/mfc handshake.
// Latency: mfc and dataOut valid WAIT_CYCLES+1 edges after the capture edge.
// Backpressure: request held until mfc; mfc held until memEn drops; one access per WAIT_CYCLES+3 cycles.
//
// Ports:
//   clk  single clock, rising edge
//   clr  synchronous active-high reset (RAM contents are kept)
//   bus  slave side of memory_responder_if (memEn/memRW/address/dataIn/dataType in,
//        dataOut/mfc out)
module memory_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2   // 0..15
) (
  input  logic               clk,
  input  logic               clr,
  memory_responder_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte storage; deliberately not reset.
  logic [7:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    mfc_q, mfc_d;
  logic [31:0]             dout_q;

  // Request fields latched on the capture edge.
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rw_q;
  logic [31:0]             din_q;
  logic [1:0]              type_q;

  logic                    capture;
  logic                    complete;
  logic                    wr_fire;

  logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
  logic [31:0]             rd_data;

  // Address bits above the decoded range are intentionally ignored (wrap).
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^bus.address[31:ADDR_WIDTH];

  //--------------------------------------------------------------------------
  // Next-state / control
  //--------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mfc_d    = mfc_q;
    capture  = 1'b0;
    complete = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mfc_d = 1'b0;
        if (bus.memEn) begin
          capture = 1'b1;
          cnt_d   = WAIT_CNT;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Withdrawal wins over completion, even on the would-be final edge.
        if (!bus.memEn) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          mfc_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (!bus.memEn) begin
          mfc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        mfc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Aligned byte lanes. Misaligned sub-fields are silently rounded down.
  //--------------------------------------------------------------------------
  always_comb begin
    a0 = addr_q;
    case (type_q)
      2'b00:   a0 = addr_q;
      2'b01:   a0 = {addr_q[ADDR_WIDTH-1:1], 1'b0};
      default: a0 = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    endcase
  end

  assign a1 = a0 + ADDR_WIDTH'(1);
  assign a2 = a0 + ADDR_WIDTH'(2);
  assign a3 = a0 + ADDR_WIDTH'(3);

  // Big-endian: lowest address lands in the most significant used byte.
  always_comb begin
    rd_data = 32'd0;
    case (type_q)
      2'b00:   rd_data = {24'd0, mem[a0]};
      2'b01:   rd_data = {16'd0, mem[a0], mem[a1]};
      default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // A reset on the completing edge discards the write.
  assign wr_fire = complete && rw_q && !clr;

  //--------------------------------------------------------------------------
  // RAM write port
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      case (type_q)
        2'b00: begin
          mem[a0] <= din_q[7:0];
        end
        2'b01: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        default: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // State, handshake and response registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mfc_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= mfc_d;
      if (capture) begin
        addr_q <= bus.address[ADDR_WIDTH-1:0];
        rw_q   <= bus.memRW;
        din_q  <= bus.dataIn;
        type_q <= bus.dataType;
      end
      // dataOut only moves on a completed read; writes leave it alone.
      if (complete && !rw_q) begin
        dout_q <= rd_data;
      end
    end
  end

  assign bus.dataOut = dout_q;
  assign bus.mfc     = mfc_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (ADDR_WIDTH=8, WAIT_CYCLES=2).
// Expected values are hand-computed big-endian byte images.
module tb_memory_responder;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  memory_responder_if bus();

  memory_responder #(
    .ADDR_WIDTH  (8),
    .WAIT_CYCLES (2)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Advance one rising edge; sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full handshake: present request, scramble inputs after the capture edge,
  // expect mfc exactly 3 edges after capture, hold in DONE for 'hold' edges,
  // then withdraw and expect mfc to fall on the next edge.
  task automatic access(input string tag, input logic rw, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] t, input int hold);
    int lat;
    bus.memEn    = 1'b1;
    bus.memRW    = rw;
    bus.address  = a;
    bus.dataIn   = d;
    bus.dataType = t;
    tick();                         // capture edge E0
    bus.memRW    = ~rw;
    bus.address  = a ^ 32'h0000_00C4;
    bus.dataIn   = ~d;
    bus.dataType = ~t;
    lat = 0;
    while (bus.mfc !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, {31'd0, bus.mfc}, 32'd1);
    end
    bus.memEn = 1'b0;
    tick();
    check({tag, "_mfc_fall"}, {31'd0, bus.mfc}, 32'd0);
  endtask

  initial begin
    int lat;

    clr          = 1'b1;
    bus.memEn    = 1'b0;
    bus.memRW    = 1'b0;
    bus.address  = 32'd0;
    bus.dataIn   = 32'd0;
    bus.dataType = 2'b10;
    tick();
    tick();
    check("rst_mfc",  {31'd0, bus.mfc}, 32'd0);
    check("rst_dout", bus.dataOut, 32'd0);
    clr = 1'b0;
    tick();
    check("idle_mfc", {31'd0, bus.mfc}, 32'd0);

    // Word write then read.
    access("wr_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 0);
    check("wr_keeps_dout", bus.dataOut, 32'd0);
    access("rd_w10", 1'b0, 32'h10, 32'h0, 2'b10, 0);
    check("rd_w10_data", bus.dataOut, 32'hDEADBEEF);

    // clr and memEn together: no capture on the reset edge, so with memEn
    // held the request is taken one edge later -> mfc 4 edges after reset.
    clr          = 1'b1;
    bus.memEn    = 1'b1;
    bus.memRW    = 1'b0;
    bus.address  = 32'h10;
    bus.dataType = 2'b10;
    tick();
    check("clr_en_dout", bus.dataOut, 32'd0);
    clr = 1'b0;
    lat = 0;
    while (bus.mfc !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("clr_en_lat", 32'(lat), 32'd4);
    check("clr_en_data", bus.dataOut, 32'hDEADBEEF);
    bus.memEn = 1'b0;
    tick();
    check("clr_en_fall", {31'd0, bus.mfc}, 32'd0);

    // Big-endian sub-word reads.
    access("rd_b11", 1'b0, 32'h11, 32'h0, 2'b00, 0);
    check("rd_b11_data", bus.dataOut, 32'h000000AD);
    access("rd_h12", 1'b0, 32'h12, 32'h0, 2'b01, 0);
    check("rd_h12_data", bus.dataOut, 32'h0000BEEF);

    // Partial write: only the low byte of dataIn goes to 0x13.
    access("wr_b13", 1'b1, 32'h13, 32'hFFFFFF55, 2'b00, 0);
    check("wr_b13_dout_hold", bus.dataOut, 32'h0000BEEF);
    access("rd_w10b", 1'b0, 32'h10, 32'h0, 2'b10, 0);
    check("rd_w10b_data", bus.dataOut, 32'hDEADBE55);
    access("rd_w12", 1'b0, 32'h12, 32'h0, 2'b10, 0);
    check("rd_w12_data", bus.dataOut, 32'hDEADBE55);
    access("rd_h13", 1'b0, 32'h13, 32'h0, 2'b01, 0);
    check("rd_h13_data", bus.dataOut, 32'h0000BE55);
    access("rd_t11", 1'b0, 32'h11, 32'h0, 2'b11, 0);
    check("rd_t11_data", bus.dataOut, 32'hDEADBE55);

    // Abort after one WAIT cycle.
    access("wr_w20", 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 0);
    bus.memEn    = 1'b1;
    bus.memRW    = 1'b1;
    bus.address  = 32'h20;
    bus.dataIn   = 32'h12345678;
    bus.dataType = 2'b10;
    tick();                         // capture
    tick();                         // one WAIT cycle
    bus.memEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_mfc", {31'd0, bus.mfc}, 32'd0);
    end
    access("rd_w20", 1'b0, 32'h20, 32'h0, 2'b10, 0);
    check("rd_w20_data", bus.dataOut, 32'hCAFEF00D);

    // Reset on what would have been the completing edge of a write.
    access("wr_w30", 1'b1, 32'h30, 32'h0BADF00D, 2'b10, 0);
    bus.memEn    = 1'b1;
    bus.memRW    = 1'b1;
    bus.address  = 32'h30;
    bus.dataIn   = 32'h11223344;
    bus.dataType = 2'b10;
    tick();                         // E0
    tick();                         // E1
    tick();                         // E2 (counter now exhausted)
    clr = 1'b1;
    tick();                         // E3 would complete; reset wins
    check("midrst_mfc",  {31'd0, bus.mfc}, 32'd0);
    check("midrst_dout", bus.dataOut, 32'd0);
    clr       = 1'b0;
    bus.memEn = 1'b0;
    tick();
    check("midrst_idle_mfc", {31'd0, bus.mfc}, 32'd0);
    access("rd_w30", 1'b0, 32'h30, 32'h0, 2'b10, 0);
    check("rd_w30_data", bus.dataOut, 32'h0BADF00D);

    // Hold in DONE for 5 cycles, and address wrap 0x100 -> 0x000.
    access("wr_w00", 1'b1, 32'h000, 32'h01020304, 2'b10, 0);
    access("rd_w100", 1'b0, 32'h100, 32'h0, 2'b10, 5);
    check("rd_w100_data", bus.dataOut, 32'h01020304);
    access("rd_b103", 1'b0, 32'hFFFF_FF03, 32'h0, 2'b00, 0);
    check("rd_b103_data", bus.dataOut, 32'h00000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-addressable RAM that acts as the responding end of the processor's memory handshake. The control unit drives `memEn`/`memRW` and waits for `mfc`; this block accepts the request, inserts a programmable number of wait states, performs a byte, halfword or word access, and raises `mfc` until the request is withdrawn. It sits between the MAR/MDR datapath and the control unit, serving both instruction fetch and load/store.

## Interface
- `ADDR_WIDTH`, 8: byte-address bits used. Memory is 2^ADDR_WIDTH bytes.
- `WAIT_CYCLES`, 2: wait states inserted before an access completes. Legal range is 0–15.
- `clk`  in  1: the single clock. All logic updates on the rising edge.
- `clr`  in  1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `memEn`  in  1: request strobe, level-sensitive, held by the initiator until `mfc`.
- `memRW`  in  1: 0 = read, 1 = write.
- `address`  in  32: byte address. Only `[ADDR_WIDTH-1:0]` is used; upper bits are ignored, so addresses wrap.
- `dataIn`  in  32: write data, right-justified.
- `dataType`  in  2: 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `dataOut`  out  32: read data, right-justified and zero-extended.
- `mfc`  out  1: memory function complete.

## Operation
- State machine with three states: IDLE, WAIT, DONE.
- Reset (`clr`=1 at an edge) forces:
  - state = IDLE, `mfc`=0, `dataOut`=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset overrides any in-flight access; a pending write is discarded.
- IDLE:
  - If `memEn`=1, latch `address`, `memRW`, `dataIn` and `dataType`.
  - Load the counter with `WAIT_CYCLES` and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If `memEn`=0, the request is aborted: go to IDLE with no RAM write and no `mfc`.
  - Else if counter≠0, decrement it.
  - Else perform the access, set `mfc`=1 and go to DONE.
- DONE:
  - Hold `mfc`=1 while `memEn`=1.
  - When `memEn`=0, clear `mfc` and go to IDLE.
- Request inputs that change after the latch edge are ignored.
- Alignment: halfword accesses force address bit 0 to 0; word accesses force bits [1:0] to 00. No fault is signalled.
- Byte order is big-endian; `a` is the aligned address:
  - Word: mem[a]↔[31:24], mem[a+1]↔[23:16], mem[a+2]↔[15:8], mem[a+3]↔[7:0].
  - Halfword: mem[a]↔[15:8], mem[a+1]↔[7:0]; `dataOut[31:16]`=0.
  - Byte: mem[a]↔[7:0]; `dataOut[31:8]`=0.
- Writes update only the addressed bytes. `dataOut` holds its previous value on a write.
- Reads update `dataOut` on the completing edge, and it holds until the next completed read.

## Timing
- Capture edge E0 is the IDLE edge with `memEn`=1.
- The completing edge is E0+`WAIT_CYCLES`+1. `mfc` and `dataOut` are valid right after it.
- Example: `WAIT_CYCLES`=2 gives `mfc` high after the third edge following capture.
- `mfc` falls on the first edge where DONE samples `memEn`=0. That edge also enters IDLE.
- Minimum request spacing:
  - A new request is accepted only from IDLE, so `memEn` must be low for at least one edge between requests.
  - Back-to-back throughput is one access per `WAIT_CYCLES`+3 cycles.
- `clr` and `memEn` asserted on the same edge: reset wins and no request is latched.
- `mfc` never asserts without a preceding capture edge.

## Test plan
- **Word write then read:** reset; write 0xDEADBEEF to address 0x10 as word; read word at 0x10.
  - `mfc` rises exactly 3 edges after each capture (`WAIT_CYCLES`=2).
  - `dataOut`=0xDEADBEEF.
- **Big-endian sub-word reads:** after the above, read a byte at 0x11 and a halfword at 0x12.
  - `dataOut`=0x000000AD, then 0x0000BEEF.
- **Partial write:** write byte 0x55 to 0x13, then read word at 0x10.
  - `dataOut`=0xDEADBE55.
  - Misaligned word read at 0x12 also returns 0xDEADBE55.
- **Abort:** start a write of 0x12345678 to 0x20; drop `memEn` after 1 WAIT cycle.
  - `mfc` stays 0.
  - A following read of 0x20 returns the old contents.
- **Reset mid-operation:** assert `clr` during WAIT of a write to 0x30.
  - `mfc`=0, `dataOut`=0, state IDLE.
  - 0x30 is unchanged.
  - The next request completes with normal latency.
- **Handshake hold and wrap:** hold `memEn` high for 5 cycles in DONE.
  - `mfc` stays 1 throughout and falls one edge after `memEn` drops.
  - A read at 0x100 returns the contents of 0x000.
